// File: rtl/apb_completer.sv
// APB completer with a small register bank (CTRL, two scratch registers, event counter, ID)
// inside a 4 KB window, programmable access-phase wait states and PSLVERR on bad accesses.
module apb_completer #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR,
  output logic [31:0] cnt_o
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [11:0] OFF_CTRL = 12'h000;
  localparam logic [11:0] OFF_SCR0 = 12'h004;
  localparam logic [11:0] OFF_SCR1 = 12'h008;
  localparam logic [11:0] OFF_CNT  = 12'h00C;
  localparam logic [11:0] OFF_ID   = 12'h010;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic [31:0] ctrl, scratch0, scratch1, cnt;
  logic [31:0] rdata;
  logic [11:0] offset;
  logic        hit, err, commit;
  logic        unused_addr;

  assign offset      = PADDR[11:0];
  assign unused_addr = ^PADDR[31:12];

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // SETUP is occupied during the first access cycle: the requester's setup cycle is seen in IDLE.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    PREADY    = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt = SETUP;
          wait_nxt  = WAIT_LOAD;
        end
      end
      SETUP, ACCESS: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (PENABLE) begin
          if (wait_cnt == 4'd0) begin
            PREADY    = 1'b1;
            state_nxt = IDLE;
          end else begin
            wait_nxt  = wait_cnt - 4'd1;
            state_nxt = ACCESS;
          end
        end else if (state == ACCESS) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hit   = 1'b1;
    rdata = '0;
    case (offset)
      OFF_CTRL: rdata = {ctrl[31:2], 1'b0, ctrl[0]};
      OFF_SCR0: rdata = scratch0;
      OFF_SCR1: rdata = scratch1;
      OFF_CNT:  rdata = cnt;
      OFF_ID:   rdata = ID_VALUE;
      default:  hit   = 1'b0;
    endcase
    err = !hit || (PADDR[1:0] != 2'b00) ||
          (PWRITE && (offset == OFF_CNT || offset == OFF_ID));
  end

  assign commit  = PREADY && PWRITE && !err;
  assign PRDATA  = (PREADY && !PWRITE && !err) ? rdata : '0;
  assign PSLVERR = PREADY && err;
  assign cnt_o   = cnt;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ctrl     <= '0;
      scratch0 <= '0;
      scratch1 <= '0;
    end else if (commit) begin
      case (offset)
        OFF_CTRL: ctrl     <= {PWDATA[31:2], 1'b0, PWDATA[0]};
        OFF_SCR0: scratch0 <= PWDATA;
        OFF_SCR1: scratch1 <= PWDATA;
        default: ;
      endcase
    end
  end

  // A clear pulse beats the increment on the same edge.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      cnt <= '0;
    end else if (commit && offset == OFF_CTRL && PWDATA[1]) begin
      cnt <= '0;
    end else if (ctrl[0]) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_apb_completer.sv
// Directed bench for apb_completer: one zero-wait and one three-wait instance on a shared bus.
module tb_apb_completer;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        psel0, psel3;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        ready0, ready3, slverr0, slverr3;
  logic [31:0] rdata0, rdata3, cnt0, cnt3;

  int vec  = 0;
  int miss = 0;

  always #5 PCLK = ~PCLK;

  apb_completer #(.WAIT_CYCLES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(ready0), .PRDATA(rdata0),
    .PSLVERR(slverr0), .cnt_o(cnt0)
  );

  apb_completer #(.WAIT_CYCLES(3)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel3), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(ready3), .PRDATA(rdata3),
    .PSLVERR(slverr3), .cnt_o(cnt3)
  );

  // One APB transfer on instance sel (0 or 3); returns data, error and access-phase length.
  task automatic xfer(input int sel, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic b2b, output logic [31:0] rd, output logic err,
                      output int acc, output logic tout);
    logic rdy;
    rd = '0; err = 1'b0; acc = 0; tout = 1'b1;
    if (!b2b) begin
      @(posedge PCLK); #1;
    end
    psel0 = (sel == 0); psel3 = (sel == 3);
    PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      acc++;
      rdy = (sel == 0) ? ready0 : ready3;
      if (rdy) begin
        rd   = (sel == 0) ? rdata0 : rdata3;
        err  = (sel == 0) ? slverr0 : slverr3;
        tout = 1'b0;
        break;
      end
    end
    @(posedge PCLK); #1;
    psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err, to; int acc;
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    vec++;
    if ({ready0, ready3, slverr0, slverr3} !== 4'b0000) begin
      miss++; $display("FAIL reset_flags: got %b want 0000", {ready0, ready3, slverr0, slverr3});
    end
    vec++;
    if ({rdata0, rdata3, cnt0, cnt3} !== 128'd0) begin
      miss++; $display("FAIL reset_data: got %h %h %h %h want all 0", rdata0, rdata3, cnt0, cnt3);
    end
    PRESET = 1'b1;
    xfer(0, 1'b0, 32'h004, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b0 || rd !== 32'h0) begin
      miss++; $display("FAIL reset_scr0: got rd=%h err=%b to=%b want 0/0/0", rd, err, to);
    end
    xfer(0, 1'b0, 32'h010, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b0 || rd !== 32'hA5B0_0001) begin
      miss++; $display("FAIL reset_id: got rd=%h err=%b want a5b00001/0", rd, err);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; logic err, to; int acc;
    xfer(0, 1'b1, 32'h004, 32'hDEAD_BEEF, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || acc != 1 || err !== 1'b0) begin
      miss++; $display("FAIL w0_write: got acc=%0d err=%b to=%b want 1/0/0", acc, err, to);
    end
    xfer(0, 1'b0, 32'h004, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || acc != 1 || rd !== 32'hDEAD_BEEF) begin
      miss++; $display("FAIL w0_read: got acc=%0d rd=%h want 1/deadbeef", acc, rd);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err, to; int acc;
    xfer(3, 1'b1, 32'h008, 32'h5A5A_0F0F, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || acc != 4 || err !== 1'b0) begin
      miss++; $display("FAIL w3_write: got acc=%0d err=%b want 4/0", acc, err);
    end
    xfer(3, 1'b0, 32'h008, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || acc != 4 || rd !== 32'h5A5A_0F0F) begin
      miss++; $display("FAIL w3_read: got acc=%0d rd=%h want 4/5a5a0f0f", acc, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err, to; int acc;
    xfer(0, 1'b1, 32'h010, 32'h1, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b1) begin
      miss++; $display("FAIL err_wr_id: got err=%b want 1", err);
    end
    xfer(0, 1'b1, 32'h020, 32'h1, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b1) begin
      miss++; $display("FAIL err_unmapped: got err=%b want 1", err);
    end
    xfer(0, 1'b0, 32'h006, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b1 || rd !== 32'h0) begin
      miss++; $display("FAIL err_misalign: got err=%b rd=%h want 1/0", err, rd);
    end
    xfer(0, 1'b1, 32'h00C, 32'h1234, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b1 || cnt0 !== 32'h0) begin
      miss++; $display("FAIL err_wr_cnt: got err=%b cnt=%h want 1/0", err, cnt0);
    end
    xfer(0, 1'b1, 32'h005, 32'hFFFF_FFFF, 1'b0, rd, err, acc, to);
    xfer(0, 1'b0, 32'h004, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (rd !== 32'hDEAD_BEEF) begin
      miss++; $display("FAIL err_no_side_effect: got scr0=%h want deadbeef", rd);
    end
    xfer(0, 1'b0, 32'h010, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b0 || rd !== 32'hA5B0_0001) begin
      miss++; $display("FAIL err_id_intact: got rd=%h err=%b want a5b00001/0", rd, err);
    end
  endtask

  task automatic test_counter();
    logic [31:0] rd; logic err, to; int acc;
    xfer(0, 1'b1, 32'h000, 32'h1, 1'b0, rd, err, acc, to);
    vec++;
    if (cnt0 !== 32'd0) begin
      miss++; $display("FAIL cnt_start: got %0d want 0", cnt0);
    end
    repeat (10) @(posedge PCLK);
    #1;
    vec++;
    if (cnt0 !== 32'd10) begin
      miss++; $display("FAIL cnt_ten: got %0d want 10", cnt0);
    end
    xfer(0, 1'b0, 32'h00C, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || err !== 1'b0 || rd !== 32'd12) begin
      miss++; $display("FAIL cnt_read: got rd=%0d err=%b want 12/0", rd, err);
    end
    xfer(0, 1'b1, 32'h000, 32'h3, 1'b0, rd, err, acc, to);
    vec++;
    if (cnt0 !== 32'd0) begin
      miss++; $display("FAIL cnt_clear: got %0d want 0", cnt0);
    end
    @(posedge PCLK); #1;
    vec++;
    if (cnt0 !== 32'd1) begin
      miss++; $display("FAIL cnt_resume: got %0d want 1", cnt0);
    end
    xfer(0, 1'b0, 32'h000, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || rd !== 32'h1) begin
      miss++; $display("FAIL ctrl_read: got %h want 00000001", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err, to; int acc;
    xfer(0, 1'b1, 32'h008, 32'h0000_0011, 1'b0, rd, err, acc, to);
    xfer(0, 1'b0, 32'h008, 32'h0, 1'b1, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || acc != 1 || rd !== 32'h0000_0011) begin
      miss++; $display("FAIL b2b_read: got acc=%0d rd=%h want 1/00000011", acc, rd);
    end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; logic err, to; int acc;
    logic seen;
    xfer(3, 1'b1, 32'h004, 32'hCAFE_0000, 1'b0, rd, err, acc, to);
    @(posedge PCLK); #1;
    psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h004; PWDATA = 32'h1234_5678;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      seen |= ready3;
    end
    @(posedge PCLK); #1;
    psel3 = 1'b0; PENABLE = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      seen |= ready3;
    end
    vec++;
    if (seen !== 1'b0) begin
      miss++; $display("FAIL abort_ready: got pready=%b want 0", seen);
    end
    xfer(3, 1'b0, 32'h004, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || rd !== 32'hCAFE_0000) begin
      miss++; $display("FAIL abort_value: got %h want cafe0000", rd);
    end
    // Reset lands in the middle of a waited write access.
    @(posedge PCLK); #1;
    psel3 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h004; PWDATA = 32'hFFFF_0000;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #3;
    PRESET = 1'b0;
    #1;
    vec++;
    if (ready3 !== 1'b0 || slverr3 !== 1'b0 || cnt0 !== 32'h0) begin
      miss++; $display("FAIL reset_mid: got pready=%b pslverr=%b cnt=%h want 0/0/0", ready3, slverr3, cnt0);
    end
    @(posedge PCLK); #1;
    psel3 = 1'b0; PENABLE = 1'b0;
    PRESET = 1'b1;
    xfer(3, 1'b0, 32'h004, 32'h0, 1'b0, rd, err, acc, to);
    vec++;
    if (to !== 1'b0 || rd !== 32'h0) begin
      miss++; $display("FAIL reset_mid_scr0: got %h want 0", rd);
    end
  endtask

  initial begin
    PRESET = 1'b0; psel0 = 1'b0; psel3 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_counter();
    test_back_to_back();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/apb_completer.md
Name: apb_completer

Overview:
APB completer (slave) that terminates one PSEL line from the APB requester and exposes a small register bank inside a 4 KB window. Supports a programmable number of wait states, error response (PSLVERR) on bad accesses, and a free-running event counter. Serves as the peripheral endpoint (RAM/P1/P2/P3 slot) on the APB bus driven by the requester.

Parameters:
WAIT_CYCLES, 0, access-phase wait states inserted before PREADY (0..15)
ID_VALUE, 32'hA5B0_0001, constant returned by the ID register

Ports:
PCLK  input  1  APB clock; all logic on rising edge
PRESET  input  1  asynchronous, active-low reset (0 = reset)
PSEL  input  1  select for this completer (one bit of the requester's PSEL vector)
PENABLE  input  1  access-phase indicator
PWRITE  input  1  1 = write, 0 = read
PADDR  input  32  byte address; only PADDR[11:0] decoded (window offset)
PWDATA  input  32  write data
PREADY  output  1  transfer completion
PRDATA  output  32  read data, valid when PREADY=1 and PWRITE=0
PSLVERR  output  1  error response, valid only when PREADY=1
cnt_o  output  32  current CNT register value (sideband to design)

Behaviour:
- Register map (offset PADDR[11:0]):
  0x000 CTRL RW: bit0 = cnt_en, bit1 = cnt_clr (write-1 pulse, self-clearing, reads 0), bits[31:2] RW storage.
  0x004 SCRATCH0 RW, 32-bit.
  0x008 SCRATCH1 RW, 32-bit.
  0x00C CNT RO: increments by 1 each cycle while cnt_en=1; wraps 32'hFFFF_FFFF -> 0.
  0x010 ID RO: ID_VALUE.
- Error conditions (PSLVERR=1 with PREADY, no register side-effect): unmapped offset; PADDR[1:0] != 0; write to CNT or ID. Reads of errored accesses return PRDATA=0.
- Reset (PRESET=0, async): FSM=IDLE, wait counter=0, CTRL/SCRATCH0/SCRATCH1/CNT=0, PREADY=0, PRDATA=0, PSLVERR=0, cnt_o=0.
- FSM states IDLE, SETUP, ACCESS:
  IDLE: PSEL=1 & PENABLE=0 -> SETUP; load wait counter with WAIT_CYCLES. PSEL=1 & PENABLE=1 in IDLE (protocol violation) -> stay IDLE, PREADY=0.
  SETUP: PSEL=1 & PENABLE=1 -> ACCESS; PSEL=0 -> IDLE (aborted, no effect).
  ACCESS: wait counter decrements each cycle while nonzero. PREADY = PSEL & PENABLE & (wait counter==0), combinational from state/counter. On PREADY=1 cycle -> IDLE, or -> SETUP if back-to-back setup follows next cycle (handled by IDLE entry rules one cycle later; requester re-enters SETUP with PENABLE=0). PSEL or PENABLE dropping before PREADY -> IDLE, no commit.
- Latency: access phase lasts exactly WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 gives zero-wait APB (PREADY high in first access cycle).
- Write commit: registers update on the PCLK edge ending the PREADY=1 cycle, only if no error.
- PRDATA/PSLVERR: driven with decoded values only while PREADY=1; 0 otherwise.
- cnt_clr and cnt_en in the same write: CNT cleared that edge, counting resumes next cycle. cnt_clr has priority over increment.
- CNT read in PREADY cycle returns the pre-edge value.
- Reset asserted mid-transfer: immediate return to reset state; pending write discarded.

Test Plan:
- Reset: PRESET=0 then release -> PREADY=0, PSLVERR=0, PRDATA=0, read 0x004 returns 0, read 0x010 returns 32'hA5B0_0001.
- WAIT_CYCLES=0: write 0x004=32'hDEAD_BEEF -> PREADY in first access cycle, PSLVERR=0; read 0x004 -> 32'hDEAD_BEEF.
- WAIT_CYCLES=3: read 0x008 -> PREADY low 3 access cycles, high on 4th; total transfer 5 cycles including setup.
- Errors: write 0x010=1, write 0x020=1, read 0x006 -> each PREADY=1 with PSLVERR=1, ID still 32'hA5B0_0001.
- Counter: write CTRL=1, wait 10 cycles, read CNT -> value consistent with 10 + access latency; write CTRL=3 -> CNT=0 next cycle then counts; CTRL reads 32'h1.
- Abort/reset: drop PSEL mid-wait on write to 0x004 -> value unchanged; assert PRESET mid-access -> PREADY=0 immediately, SCRATCH0=0.
